// File: rtl/redundant_compare_monitor_pkg.sv
// Shared types and constants for the redundant comparator health monitor.
// The state encoding is also the value seen on the external state port.
package rcmp_mon_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_e;

    localparam int RUN_W = 4;

endpackage

// File: rtl/redundant_compare_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/redundant_compare_monitor.sv
// Health monitor for a dual-channel redundant equality comparator: grades the
// channel OK/SUSPECT/FAULT from error history and forwards a fail-safe equality.
module redundant_compare_monitor
    import rcmp_mon_pkg::*;
#(
    parameter int ERR_CNT_W      = 8,
    parameter int FAULT_THRESH   = 3,
    parameter int RECOVER_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic                 eq_in,
    input  logic                 err_in,
    input  logic                 clear,
    output logic                 eq_out,
    output logic                 eq_out_valid,
    output logic [1:0]           state,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [RUN_W-1:0] FAULT_T   = RUN_W'(FAULT_THRESH);
    localparam logic [RUN_W-1:0] RECOVER_T = RUN_W'(RECOVER_THRESH);

    mon_state_e       state_q, state_n;
    logic [RUN_W-1:0] err_run_q, err_run_n;
    logic [RUN_W-1:0] clean_run_q, clean_run_n;
    logic [RUN_W-1:0] err_inc, clean_inc;
    logic             eq_q, eq_n;
    logic             eq_valid_q, eq_valid_n;

    // Handshake: sample_valid has no back-pressure; every cycle it is high
    // (and clear is low) the sample is consumed, and eq_out_valid pulses for
    // exactly one cycle on the following cycle with eq_out carrying its result.
    assign err_inc   = err_run_q + 1'b1;
    assign clean_inc = clean_run_q + 1'b1;

    always_comb begin
        state_n     = state_q;
        err_run_n   = err_run_q;
        clean_run_n = clean_run_q;
        eq_n        = eq_q;
        eq_valid_n  = 1'b0;
        if (clear) begin
            state_n     = ST_OK;
            err_run_n   = '0;
            clean_run_n = '0;
            eq_n        = 1'b0;
        end else if (sample_valid) begin
            eq_valid_n = 1'b1;
            case (state_q)
                ST_OK, ST_SUSPECT: begin
                    if (err_in) begin
                        // err_run is 0 in OK, so the first error always lands on 1
                        err_run_n   = err_inc;
                        clean_run_n = '0;
                        state_n     = (err_inc == FAULT_T) ? ST_FAULT : ST_SUSPECT;
                    end else if (state_q == ST_SUSPECT) begin
                        err_run_n = '0;
                        if (clean_inc == RECOVER_T) begin
                            state_n     = ST_OK;
                            clean_run_n = '0;
                        end else begin
                            clean_run_n = clean_inc;
                        end
                    end
                end
                default: ;
            endcase
            eq_n = eq_in & ~err_in & (state_n != ST_FAULT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OK;
            err_run_q   <= '0;
            clean_run_q <= '0;
            eq_q        <= 1'b0;
            eq_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            err_run_q   <= err_run_n;
            clean_run_q <= clean_run_n;
            eq_q        <= eq_n;
            eq_valid_q  <= eq_valid_n;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sample_valid & err_in & ~clear),
        .clr   (clear),
        .count (err_count)
    );

    assign eq_out       = eq_q;
    assign eq_out_valid = eq_valid_q;
    assign state        = state_q;
    assign fault        = (state_q == ST_FAULT);

endmodule

// File: tb/tb_redundant_compare_monitor.sv
// Directed bench for redundant_compare_monitor: default-parameter instance plus
// a narrow-counter instance for saturation.
module tb_redundant_compare_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0, eq_in = 1'b0, err_in = 1'b0, clear = 1'b0;
    logic       eq_out, eq_out_valid, fault;
    logic [1:0] state;
    logic [7:0] err_count;

    logic       sv2 = 1'b0, eq2 = 1'b0, err2 = 1'b0, clr2 = 1'b0;
    logic       eq_out2, eq_out_valid2, fault2;
    logic [1:0] state2;
    logic [1:0] err_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    redundant_compare_monitor dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .eq_in(eq_in),
        .err_in(err_in), .clear(clear), .eq_out(eq_out), .eq_out_valid(eq_out_valid),
        .state(state), .fault(fault), .err_count(err_count)
    );

    redundant_compare_monitor #(.ERR_CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv2), .eq_in(eq2),
        .err_in(err2), .clear(clr2), .eq_out(eq_out2), .eq_out_valid(eq_out_valid2),
        .state(state2), .fault(fault2), .err_count(err_count2)
    );

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic step(input logic sv, input logic eq, input logic er, input logic clr);
        @(negedge clk);
        sample_valid = sv; eq_in = eq; err_in = er; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (eq_out !== 1'b0) begin errors++; $display("FAIL reset_eq_out: got %b want 0", eq_out); end
        checks++; if (eq_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", eq_out_valid); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_stream();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++; if (eq_out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid[%0d]: got %b want 1", i, eq_out_valid); end
            checks++; if (eq_out !== 1'b1) begin errors++; $display("FAIL clean_eq[%0d]: got %b want 1", i, eq_out); end
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL clean_state[%0d]: got %0d want 0", i, state); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (eq_out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", eq_out_valid); end
        checks++; if (eq_out !== 1'b1) begin errors++; $display("FAIL idle_eq_hold: got %b want 1", eq_out); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_alternating();
        logic exp_eq [4];
        logic er;
        exp_eq = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            er = (i % 2 == 0);
            step(1'b1, 1'b1, er, 1'b0);
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL alt_state[%0d]: got %0d want 1", i, state); end
            checks++; if (eq_out !== exp_eq[i]) begin errors++; $display("FAIL alt_eq[%0d]: got %b want %b", i, eq_out, exp_eq[i]); end
        end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL alt_err_count: got %0d want 2", err_count); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (state !== 2'd0 || err_count !== 8'd0) begin errors++; $display("FAIL alt_clear: got state=%0d count=%0d want 0/0", state, err_count); end
    endtask

    task automatic test_fault();
        logic [1:0] exp_st [3];
        exp_st = '{2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL fault_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            checks++; if (fault !== (i == 2)) begin errors++; $display("FAIL fault_flag[%0d]: got %b want %b", i, fault, (i == 2)); end
        end
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL fault_err_count: got %0d want 3", err_count); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++; if (eq_out_valid !== 1'b1 || eq_out !== 1'b0) begin errors++; $display("FAIL fault_forced_eq[%0d]: got valid=%b eq=%b want 1/0", i, eq_out_valid, eq_out); end
            checks++; if (state !== 2'd2) begin errors++; $display("FAIL fault_absorb[%0d]: got %0d want 2", i, state); end
        end
    endtask

    task automatic test_clear_priority();
        step(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clr_state: got %0d want 0", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_fault: got %b want 0", fault); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_err_count: got %0d want 0", err_count); end
        checks++; if (eq_out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", eq_out_valid); end
        checks++; if (eq_out !== 1'b0) begin errors++; $display("FAIL clr_eq: got %b want 0", eq_out); end
    endtask

    task automatic test_recover();
        logic [1:0] exp_st [4];
        logic [1:0] exp_err_st [3];
        exp_st = '{2'd1, 2'd1, 2'd1, 2'd0};
        exp_err_st = '{2'd1, 2'd1, 2'd2};
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rec_enter: got %0d want 1", state); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL rec_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
        end
        // A single error after recovery must restart the run at 1: fault comes on the third.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            checks++; if (state !== exp_err_st[i]) begin errors++; $display("FAIL rec_rerun[%0d]: got %0d want %0d", i, state, exp_err_st[i]); end
        end
        checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL rec_err_count: got %0d want 4", err_count); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sv2 = 1'b1; eq2 = 1'b0; err2 = 1'b1; clr2 = 1'b0;
            @(posedge clk);
            #1;
            checks++; if (err_count2 !== exp_cnt[i]) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, err_count2, exp_cnt[i]); end
        end
        @(negedge clk);
        sv2 = 1'b0; err2 = 1'b0;
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'd1 || err_count !== 8'd2 || eq_out_valid !== 1'b1) begin
            errors++; $display("FAIL arst_setup: got state=%0d count=%0d valid=%b want 1/2/1", state, err_count, eq_out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d want 0", state); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL arst_err_count: got %0d want 0", err_count); end
        checks++; if (eq_out_valid !== 1'b0 || eq_out !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL arst_outputs: got valid=%b eq=%b fault=%b want 0/0/0", eq_out_valid, eq_out, fault);
        end
        @(negedge clk);
        sample_valid = 1'b0; err_in = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (eq_out_valid !== 1'b1 || eq_out !== 1'b1 || state !== 2'd0) begin
            errors++; $display("FAIL arst_after: got valid=%b eq=%b state=%0d want 1/1/0", eq_out_valid, eq_out, state);
        end
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_alternating();
        test_fault();
        test_clear_priority();
        test_recover();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
